// File: rtl/tlb_ptw_pkg.sv
// Shared types and constants for the tlb_ptw page-table walker.
// Optional superpage support is selected by defining TLB_PTW_SUPERPAGE_EN.
package tlb_ptw_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam int PTE_V      = 0;
   localparam int PTE_L      = 1;
   localparam int PTE_BYTES  = 8;
   localparam int PTE_SHIFT  = $clog2(PTE_BYTES);
   localparam int DEF_LEVELS = 4;
   localparam int DEF_IDX    = 9;

endpackage

// File: rtl/tlb_ptw_pte_check.sv
// Combinational PTE decode for one walk step: descend, leaf or fault, plus leaf PPN.
// Superpage leaves above level 0 are accepted only when TLB_PTW_SUPERPAGE_EN is defined.
module tlb_ptw_pte_check
   import tlb_ptw_pkg::*;
#(
   parameter int addr   = 64,
   parameter int page   = 12,
   parameter int levels = DEF_LEVELS,
   parameter int idx    = DEF_IDX
) (
   input  logic [63:0]               i_pte,
   input  logic [$clog2(levels)-1:0] i_lvl,
   input  logic [addr-page-1:0]      i_vpn,
   output logic                      o_next,
   output logic                      o_leaf,
   output logic                      o_fault,
   output logic [addr-page-1:0]      o_ppn
);

   localparam int VW = addr - page;

   logic          w_v;
   logic          w_l;
   logic [VW-1:0] w_ppn;
   logic          w_unused;

   assign w_v   = i_pte[PTE_V];
   assign w_l   = i_pte[PTE_L];
   assign w_ppn = i_pte[addr-1:page];

`ifdef TLB_PTW_SUPERPAGE_EN
   // Bits of the PPN that a level-lvl superpage takes from the VPN instead
   logic [VW-1:0] w_mask;
   assign w_mask   = ~({VW{1'b1}} << (int'(i_lvl) * idx));
   assign w_unused = ^i_pte[page-1:2];
`else
   assign w_unused = ^{i_pte[page-1:2], i_vpn};
`endif

   always_comb begin
      o_next  = 1'b0;
      o_leaf  = 1'b0;
      o_fault = 1'b0;
      o_ppn   = '0;
      if (!w_v) begin
         o_fault = 1'b1;
      end else if (w_l && i_lvl == '0) begin
         o_leaf = 1'b1;
         o_ppn  = w_ppn;
      end else if (w_l) begin
`ifdef TLB_PTW_SUPERPAGE_EN
         if ((w_ppn & w_mask) != '0) begin
            o_fault = 1'b1;
         end else begin
            o_leaf = 1'b1;
            o_ppn  = (w_ppn & ~w_mask) | (i_vpn & w_mask);
         end
`else
         o_fault = 1'b1;
`endif
      end else if (i_lvl == '0) begin
         o_fault = 1'b1;
      end else begin
         o_next = 1'b1;
      end
   end

endmodule

// File: rtl/tlb_ptw.sv
// Single-walk radix page-table walker producing TLB refill entries.
// Define TLB_PTW_SUPERPAGE_EN to accept aligned leaves above level 0.
module tlb_ptw
   import tlb_ptw_pkg::*;
#(
   parameter int addr   = 64,
   parameter int page   = 12,
   parameter int pcid   = 12,
   parameter int levels = DEF_LEVELS,
   parameter int idx    = DEF_IDX
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [addr-1:0]           in_ptbr,
   input  logic                      miss_valid,
   output logic                      miss_ready,
   input  logic [addr-1:0]           miss_addr,
   input  logic [pcid-1:0]           miss_pcid,
   output logic                      mem_req_valid,
   input  logic                      mem_req_ready,
   output logic [addr-1:0]           mem_req_addr,
   input  logic                      mem_resp_valid,
   input  logic [63:0]               mem_resp_data,
   output logic                      refill_valid,
   input  logic                      refill_ready,
   output logic [addr-page-1:0]      refill_vpn,
   output logic [pcid-1:0]           refill_pcid,
   output logic [addr-page-1:0]      refill_ppn,
   output logic [$clog2(levels)-1:0] refill_level,
   output logic                      refill_fault
);

   localparam int LW = $clog2(levels);
   localparam int VW = addr - page;

   state_t          r_state;
   logic [LW-1:0]   r_lvl;
   logic [VW-1:0]   r_vpn;
   logic [pcid-1:0] r_pcid;
   logic [addr-1:0] r_req_addr;
   logic            r_miss_ready;
   logic            r_req_valid;
   logic            r_refill_valid;
   logic [VW-1:0]   r_refill_ppn;
   logic [LW-1:0]   r_refill_level;
   logic            r_refill_fault;

   logic [addr-1:0] w_root;
   logic [addr-1:0] w_next_base;
   logic            w_next;
   logic            w_leaf;
   logic            w_fault;
   logic [VW-1:0]   w_ppn;
   logic            w_unused;

   assign w_root      = {in_ptbr[addr-1:page], {page{1'b0}}};
   assign w_next_base = {mem_resp_data[addr-1:page], {page{1'b0}}};
   assign w_unused    = ^{in_ptbr[page-1:0], miss_addr[page-1:0]};

   // Byte address of the PTE indexed by this level's VPN slice, wrapping mod 2^addr
   function automatic logic [addr-1:0] f_pte_addr(input logic [addr-1:0] base,
                                                  input logic [VW-1:0]   vpn,
                                                  input logic [LW-1:0]   lvl);
      logic [VW-1:0]   w_sh;
      logic [addr-1:0] w_off;
      w_sh  = vpn >> (int'(lvl) * idx);
      w_off = '0;
      w_off[idx+PTE_SHIFT-1:PTE_SHIFT] = w_sh[idx-1:0];
      return base + w_off;
   endfunction

   tlb_ptw_pte_check #(
      .addr   (addr),
      .page   (page),
      .levels (levels),
      .idx    (idx)
   ) u_pte_check (
      .i_pte   (mem_resp_data),
      .i_lvl   (r_lvl),
      .i_vpn   (r_vpn),
      .o_next  (w_next),
      .o_leaf  (w_leaf),
      .o_fault (w_fault),
      .o_ppn   (w_ppn)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= S_IDLE;
         r_lvl          <= '0;
         r_vpn          <= '0;
         r_pcid         <= '0;
         r_req_addr     <= '0;
         r_miss_ready   <= 1'b1;
         r_req_valid    <= 1'b0;
         r_refill_valid <= 1'b0;
         r_refill_ppn   <= '0;
         r_refill_level <= '0;
         r_refill_fault <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (miss_valid) begin
                  r_vpn        <= miss_addr[addr-1:page];
                  r_pcid       <= miss_pcid;
                  r_lvl        <= LW'(levels - 1);
                  r_req_addr   <= f_pte_addr(w_root, miss_addr[addr-1:page], LW'(levels - 1));
                  r_req_valid  <= 1'b1;
                  r_miss_ready <= 1'b0;
                  r_state      <= S_REQ;
               end
            end
            S_REQ: begin
               if (mem_req_ready) begin
                  r_req_valid <= 1'b0;
                  r_state     <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (mem_resp_valid) begin
                  if (w_next) begin
                     r_lvl       <= r_lvl - LW'(1);
                     r_req_addr  <= f_pte_addr(w_next_base, r_vpn, r_lvl - LW'(1));
                     r_req_valid <= 1'b1;
                     r_state     <= S_REQ;
                  end else begin
                     r_refill_ppn   <= w_leaf ? w_ppn : '0;
                     r_refill_fault <= w_fault;
                     r_refill_level <= r_lvl;
                     r_refill_valid <= 1'b1;
                     r_state        <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               // miss_ready rises only once back in IDLE, so refill_ready never reaches it combinationally
               if (refill_ready) begin
                  r_refill_valid <= 1'b0;
                  r_miss_ready   <= 1'b1;
                  r_state        <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign miss_ready    = r_miss_ready;
   assign mem_req_valid = r_req_valid;
   assign mem_req_addr  = r_req_addr;
   assign refill_valid  = r_refill_valid;
   assign refill_vpn    = r_vpn;
   assign refill_pcid   = r_pcid;
   assign refill_ppn    = r_refill_ppn;
   assign refill_level  = r_refill_level;
   assign refill_fault  = r_refill_fault;

endmodule

// File: tb/tb_tlb_ptw.sv
// Self-checking bench for tlb_ptw: directed table, reset corner case, randomized walks.
// Honours TLB_PTW_SUPERPAGE_EN in both the vector table and the reference model.
module tb_tlb_ptw;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] in_ptbr;
   logic        miss_valid;
   logic        miss_ready;
   logic [63:0] miss_addr;
   logic [11:0] miss_pcid;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [63:0] mem_req_addr;
   logic        mem_resp_valid;
   logic [63:0] mem_resp_data;
   logic        refill_valid;
   logic        refill_ready;
   logic [51:0] refill_vpn;
   logic [11:0] refill_pcid;
   logic [51:0] refill_ppn;
   logic [1:0]  refill_level;
   logic        refill_fault;

   always #5 clk = ~clk;

   tlb_ptw dut (
      .clk(clk), .rst(rst), .in_ptbr(in_ptbr),
      .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr), .miss_pcid(miss_pcid),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
      .refill_valid(refill_valid), .refill_ready(refill_ready), .refill_vpn(refill_vpn),
      .refill_pcid(refill_pcid), .refill_ppn(refill_ppn), .refill_level(refill_level),
      .refill_fault(refill_fault)
   );

   int          n_vec = 0;
   int          n_err = 0;
   logic [63:0] pmem [logic [63:0]];
   logic [63:0] exp_q [$];
   int          n_acc = 0;
   bit          mon_en = 0;
   bit          rnd_rdy = 0;
   int          stall_left = 0;
   int          resp_delay = 1;
   int          pend_cnt = 0;
   logic [63:0] pend_data = '0;
   bit          prev_wait = 0;

   typedef struct {
      string       nm;
      logic [63:0] va;
      int          term;
      int          kind;      // 0 leaf, 1 invalid, 2 non-leaf pointer
      logic [51:0] lppn;
      int          req_stall;
      int          ref_stall;
      int          cyc;
      logic [51:0] e_ppn;
      int          e_lvl;
      bit          e_flt;
      int          e_nreq;
   } vec_t;
   vec_t tbl [$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, expv);
      end
   endtask

   task automatic add(input string nm, input int term, input int kind, input logic [51:0] lppn,
                      input int rqs, input int rfs, input int cyc, input logic [51:0] eppn,
                      input int elvl, input bit eflt, input int enreq);
      vec_t v;
      v.nm = nm; v.va = 64'h0000_00AB_CDE5_5123; v.term = term; v.kind = kind; v.lppn = lppn;
      v.req_stall = rqs; v.ref_stall = rfs; v.cyc = cyc; v.e_ppn = eppn; v.e_lvl = elvl;
      v.e_flt = eflt; v.e_nreq = enreq;
      tbl.push_back(v);
   endtask

   // Reference walk over the sparse memory image; also records the expected PTE addresses
   task automatic model(input logic [63:0] ptbr, input logic [63:0] va,
                        output logic [51:0] ppn, output int lvl_o, output bit flt);
      logic [63:0] base, a, p, ix;
      logic [51:0] vpn, msk;
      base = {ptbr[63:12], 12'h0};
      vpn  = va[63:12];
      exp_q.delete();
      ppn = '0; flt = 1'b1; lvl_o = 0;
      for (int l = 3; l >= 0; l--) begin
         ix = 64'((vpn >> (9 * l)) & 52'h1ff);
         a  = base + (ix << 3);
         p  = pmem.exists(a) ? pmem[a] : 64'h0;
         exp_q.push_back(a);
         lvl_o = l;
         if (!p[0]) return;
         if (p[1]) begin
            if (l == 0) begin
               ppn = p[63:12]; flt = 1'b0;
               return;
            end
            msk = (52'h1 << (9 * l)) - 52'h1;
`ifdef TLB_PTW_SUPERPAGE_EN
            if ((p[63:12] & msk) == '0) begin
               ppn = p[63:12] | (vpn & msk); flt = 1'b0;
            end
`else
            if (msk == '0) flt = 1'b0;
`endif
            return;
         end
         if (l == 0) return;
         base = {p[63:12], 12'h0};
      end
   endtask

   task automatic build(input logic [63:0] ptbr, input logic [63:0] va, input int term,
                        input int kind, input logic [51:0] lppn);
      logic [63:0] base, a, nb;
      logic [51:0] vpn;
      pmem.delete();
      base = {ptbr[63:12], 12'h0};
      vpn  = va[63:12];
      for (int l = 3; l >= term; l--) begin
         a = base + (64'((vpn >> (9 * l)) & 52'h1ff) << 3);
         if (l > term) begin
            nb = 64'h0000_0010_0000_0000 + 64'(l) * 64'h3000;
            pmem[a] = nb | 64'h1;
            base = nb;
         end else if (kind == 0) pmem[a] = {lppn, 12'h003};
         else if (kind == 1) pmem[a] = {lppn, 12'h002};
         else pmem[a] = {lppn, 12'h001};
      end
   endtask

   task automatic build_rnd(input logic [63:0] ptbr, input logic [63:0] va);
      logic [63:0] base, a, nb, junk;
      logic [51:0] vpn, ppn;
      int r;
      pmem.delete();
      base = {ptbr[63:12], 12'h0};
      vpn  = va[63:12];
      for (int l = 3; l >= 0; l--) begin
         a    = base + (64'((vpn >> (9 * l)) & 52'h1ff) << 3);
         r    = $urandom_range(0, 99);
         junk = 64'($urandom) & 64'hffc;
         nb   = {$urandom, $urandom} & ~64'hfff;
         if (r < 8) begin
            pmem[a] = (nb | junk) & ~64'h1;
            break;
         end else if (r < 25 || (l == 0 && r < 85)) begin
            ppn = nb[63:12];
            if ($urandom_range(0, 1) == 1) ppn = ppn & ~((52'h1 << (9 * l)) - 52'h1);
            pmem[a] = {ppn, 12'h0} | junk | 64'h3;
            break;
         end else begin
            pmem[a] = nb | junk | 64'h1;
            base = nb;
         end
      end
   endtask

   // Memory side: stalls/acceptance, delayed single-pulse response, request address checks
   initial begin
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      forever begin
         @(negedge clk);
         mem_resp_valid = 1'b0;
         if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
               mem_resp_valid = 1'b1;
               mem_resp_data  = pend_data;
            end
         end
         if (mon_en) begin
            if (prev_wait) chk("req_hold", 64'(mem_req_valid), 64'd1);
            if (mem_req_valid) begin
               if (n_acc < exp_q.size()) chk($sformatf("req_addr%0d", n_acc), mem_req_addr, exp_q[n_acc]);
               else begin
                  n_vec++; n_err++;
                  $display("FAIL req_extra: got request %h, expected none", mem_req_addr);
               end
            end
         end
         if (mem_req_valid && stall_left > 0) begin
            mem_req_ready = 1'b0;
            stall_left--;
         end else mem_req_ready = rnd_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
         prev_wait = mem_req_valid && !mem_req_ready;
         if (mem_req_valid && mem_req_ready) begin
            pend_cnt  = resp_delay;
            pend_data = pmem.exists(mem_req_addr) ? pmem[mem_req_addr] : 64'h0;
            n_acc++;
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1; miss_valid = 1'b0; refill_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Issues one miss and checks refill contents, latency, hold behaviour and handshake
   task automatic run_walk(input string nm, input logic [63:0] ptbr, input logic [63:0] va,
                           input logic [11:0] pc, input int ref_stall, input int exp_cyc,
                           input logic [51:0] e_ppn, input int e_lvl, input bit e_flt, input int e_nreq);
      int cyc;
      chk({nm, ".idle_ready"}, 64'(miss_ready), 64'd1);
      n_acc = 0; mon_en = 1'b1;
      in_ptbr = ptbr; miss_addr = va; miss_pcid = pc; miss_valid = 1'b1;
      @(negedge clk);
      miss_valid = 1'b0;
      cyc = 1;
      while (!refill_valid && cyc < 300) begin
         @(negedge clk);
         cyc++;
      end
      if (!refill_valid) begin
         n_vec++; n_err++;
         $display("FAIL %s.timeout: no refill after %0d cycles", nm, cyc);
         mon_en = 1'b0;
         do_reset();
         return;
      end
      if (exp_cyc > 0) chk({nm, ".latency"}, 64'(cyc), 64'(exp_cyc));
      for (int k = 0; k <= ref_stall; k++) begin
         chk({nm, ".valid"}, 64'(refill_valid), 64'd1);
         chk({nm, ".vpn"}, 64'(refill_vpn), 64'(va[63:12]));
         chk({nm, ".pcid"}, 64'(refill_pcid), 64'(pc));
         chk({nm, ".ppn"}, 64'(refill_ppn), 64'(e_ppn));
         chk({nm, ".level"}, 64'(refill_level), 64'(e_lvl));
         chk({nm, ".fault"}, 64'(refill_fault), 64'(e_flt));
         chk({nm, ".busy"}, 64'(miss_ready), 64'd0);
         if (k == ref_stall) refill_ready = 1'b1;
         @(negedge clk);
      end
      refill_ready = 1'b0;
      chk({nm, ".rv_clear"}, 64'(refill_valid), 64'd0);
      chk({nm, ".ready_again"}, 64'(miss_ready), 64'd1);
      chk({nm, ".nreq"}, 64'(n_acc), 64'(e_nreq));
      mon_en = 1'b0;
   endtask

   localparam logic [63:0] PTBR = 64'h0000_0000_8000_0abc;

   initial begin
      logic [51:0] e_ppn;
      int          e_lvl;
      bit          e_flt;
      logic [63:0] rp, rv;
      in_ptbr = '0; miss_addr = '0; miss_pcid = '0;
      do_reset();
      @(negedge clk);
      chk("rst.miss_ready", 64'(miss_ready), 64'd1);
      chk("rst.req_valid", 64'(mem_req_valid), 64'd0);
      chk("rst.refill_valid", 64'(refill_valid), 64'd0);
      chk("rst.ppn", 64'(refill_ppn), 64'd0);
      chk("rst.vpn", 64'(refill_vpn), 64'd0);
      chk("rst.level", 64'(refill_level), 64'd0);
      chk("rst.fault", 64'(refill_fault), 64'd0);

      add("full4",  0, 0, 52'h12345, 0, 0, 9,  52'h12345, 0, 1'b0, 4);
      add("inval2", 2, 1, 52'h00777, 0, 0, 5,  52'h0,     2, 1'b1, 2);
`ifdef TLB_PTW_SUPERPAGE_EN
      add("super1", 1, 0, 52'h40000, 0, 0, 7,  52'h40055, 1, 1'b0, 3);
`else
      add("super1", 1, 0, 52'h40000, 0, 0, 7,  52'h0,     1, 1'b1, 3);
`endif
      add("stall",  0, 0, 52'hABCDE, 5, 3, 14, 52'hABCDE, 0, 1'b0, 4);
      add("l0ptr",  0, 2, 52'h00123, 0, 0, 9,  52'h0,     0, 1'b1, 4);
      add("inval3", 3, 1, 52'h00000, 0, 0, 3,  52'h0,     3, 1'b1, 1);
      add("misal2", 2, 0, 52'h40001, 0, 0, 5,  52'h0,     2, 1'b1, 2);

      for (int i = 0; i < tbl.size(); i++) begin
         build(PTBR, tbl[i].va, tbl[i].term, tbl[i].kind, tbl[i].lppn);
         model(PTBR, tbl[i].va, e_ppn, e_lvl, e_flt);
         stall_left = tbl[i].req_stall;
         run_walk(tbl[i].nm, PTBR, tbl[i].va, 12'(12'h100 + i), tbl[i].ref_stall, tbl[i].cyc,
                  tbl[i].e_ppn, tbl[i].e_lvl, tbl[i].e_flt, tbl[i].e_nreq);
      end

      // Reset in WAIT with the response arriving after reset has taken effect
      build(PTBR, tbl[0].va, 0, 0, 52'h12345);
      resp_delay = 2;
      in_ptbr = PTBR; miss_addr = tbl[0].va; miss_pcid = 12'h5a5; miss_valid = 1'b1;
      @(negedge clk);
      miss_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rstw.miss_ready", 64'(miss_ready), 64'd1);
      chk("rstw.ppn_cleared", 64'(refill_ppn), 64'd0);
      chk("rstw.stale_resp_seen", 64'(mem_resp_valid), 64'd1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("rstw.no_req", 64'(mem_req_valid), 64'd0);
         chk("rstw.no_refill", 64'(refill_valid), 64'd0);
         chk("rstw.idle", 64'(miss_ready), 64'd1);
      end
      resp_delay = 1;
      model(PTBR, tbl[0].va, e_ppn, e_lvl, e_flt);
      run_walk("after_rst", PTBR, tbl[0].va, 12'h3c3, 0, 9, 52'h12345, 0, 1'b0, 4);

      // Randomized walks against the reference model
      rnd_rdy = 1'b1;
      for (int t = 0; t < 40; t++) begin
         rp = {$urandom, $urandom};
         rv = {$urandom, $urandom};
         build_rnd(rp, rv);
         model(rp, rv, e_ppn, e_lvl, e_flt);
         resp_delay = $urandom_range(1, 3);
         run_walk($sformatf("rnd%0d", t), rp, rv, 12'($urandom), $urandom_range(0, 2), -1,
                  e_ppn, e_lvl, e_flt, exp_q.size());
      end
      rnd_rdy = 1'b0;
      resp_delay = 1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/tlb_ptw.md
# tlb_ptw

Hardware page-table walker sitting directly downstream of the set-associative TLB `cache`. It accepts one miss (virtual address plus PCID), walks a multi-level radix page table through a single-outstanding memory request/response port, and returns a refill entry (tag, PCID, physical page number, level, fault) for the TLB to install. It handles one walk at a time; further misses are back-pressured.

## Interface
Parameters:
- `addr`, 64, virtual/physical address width in bits
- `page`, 12, page-offset width in bits
- `pcid`, 12, PCID width in bits
- `levels`, 4, page-table levels walked
- `idx`, 9, VPN index bits per level

Ports:
- `clk`  in  1  single clock; all logic on posedge
- `rst`  in  1  synchronous, active-high reset
- `in_ptbr`  in  addr  root table physical base; page-aligned, low `page` bits ignored
- `miss_valid`  in  1  TLB miss request present
- `miss_ready`  out  1  walker can accept a miss
- `miss_addr`  in  addr  faulting virtual address
- `miss_pcid`  in  pcid  PCID of the miss
- `mem_req_valid`  out  1  PTE read request
- `mem_req_ready`  in  1  memory accepts request
- `mem_req_addr`  out  addr  PTE byte address, 8-byte aligned
- `mem_resp_valid`  in  1  PTE data returned; single-cycle pulse
- `mem_resp_data`  in  64  PTE
- `refill_valid`  out  1  refill entry available
- `refill_ready`  in  1  TLB consumes refill
- `refill_vpn`  out  addr-page  VPN of the walked address
- `refill_pcid`  out  pcid  PCID of the walk
- `refill_ppn`  out  addr-page  translated PPN
- `refill_level`  out  clog2(levels)  level of the leaf; 0 = 4 KiB
- `refill_fault`  out  1  walk faulted; `refill_ppn` = 0

## Operation
- PTE format: bit0 V, bit1 L (leaf), bits [addr-1:page] PPN; other bits ignored.
- States: IDLE, REQ, WAIT, DONE.
- IDLE: `miss_ready`=1. On `miss_valid`: latch `miss_addr[addr-1:page]`, `miss_pcid`, base = `in_ptbr` with low `page` bits cleared, lvl = `levels-1` -> REQ.
- REQ: `mem_req_valid`=1, `mem_req_addr` = base + (VPN[lvl*idx +: idx] << 3), computed modulo 2^addr. Held stable until `mem_req_ready` -> WAIT.
- WAIT: on `mem_resp_valid` evaluate PTE:
  - V=0 -> fault -> DONE.
  - L=1 at lvl 0 -> leaf -> DONE.
  - L=1 at lvl>0 -> superpage handling (see Configuration).
  - L=0 at lvl 0 -> fault -> DONE.
  - L=0 at lvl>0 -> base = {PTE.PPN, page'b0}, lvl-1 -> REQ.
- DONE: `refill_valid`=1, outputs held stable until `refill_ready` -> IDLE. `miss_ready` stays 0 until IDLE.
- `refill_level` = lvl at termination. On fault, `refill_ppn`=0, `refill_level`=lvl reached.
- `mem_resp_valid` outside WAIT is ignored; memory returns exactly one response per accepted request.

## Timing
- Reset: state IDLE; `miss_ready`=1; `mem_req_valid`=0; `refill_valid`=0; all latched data and `refill_*` = 0.
- Miss accepted at cycle 0 -> `mem_req_valid` at cycle 1.
- With `mem_req_ready`=1 and response one cycle after acceptance: 2 cycles per level; full 4-level walk gives `refill_valid` at cycle 9.
- `mem_req_valid` never drops before acceptance; `mem_req_addr` never changes while valid.
- `rst` mid-walk: return to IDLE next cycle, dropping the walk; any later in-flight response is ignored.
- No combinational path from `refill_ready` to `miss_ready`; a new miss is accepted at the earliest one cycle after the refill handshake.

## Configuration
- `TLB_PTW_SUPERPAGE_EN` defined: L=1 at lvl>0 is a valid leaf if PTE.PPN low lvl*idx bits are 0. `refill_ppn` = PTE.PPN with low lvl*idx bits replaced by VPN low lvl*idx bits. Nonzero low bits (misaligned) -> fault.
- Not defined: any L=1 at lvl>0 -> fault; `refill_level` is always 0 on success.

## Structure
- Package `tlb_ptw_pkg`: state enum, PTE_V/PTE_L bit positions, PTE_BYTES=8, default level/index widths.
- Sub-module `tlb_ptw_pte_check`: combinational PTE decode; outputs next/leaf/fault and the composed PPN for a given lvl; hosts the `TLB_PTW_SUPERPAGE_EN` logic.

## Test plan
- 4-level walk, all intermediate PTEs V=1 L=0, leaf PPN 0x12345, zero-wait memory -> `refill_valid` at cycle 9, `refill_ppn`=0x12345, `refill_level`=0, fault=0; the four `mem_req_addr` values match base + index×8.
- Level-2 PTE V=0 -> fault after 2 requests, `refill_ppn`=0, `refill_level`=2.
- Level-1 leaf PPN 0x40000 (aligned) -> with macro: ppn = 0x40000|VPN[8:0], level 1; without macro: fault.
- `mem_req_ready` low for 5 cycles -> `mem_req_valid`/`mem_req_addr` stable, walk completes correctly; `refill_ready` held low 3 cycles -> outputs stable, `miss_ready`=0.
- `rst` asserted while in WAIT, stale response arrives next cycle -> IDLE, no refill, no request; a new miss walks normally.
